// File: rtl/ftdi_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_arb_pkg
//  Purpose  : Shared constants for the FTDI TX packet arbiter and its
//             round-robin picker (FSM encoding, header layout, limits).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ftdi_arb_pkg;

  // Arbiter FSM encoding
  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Header beat layout: magic byte in [7:0], source channel in [15:8]
  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_FIELD_W   = 8;
  localparam int         HDR_MAGIC_LSB = 0;
  localparam int         HDR_CH_LSB    = 8;

  // Channel limits and status widths
  localparam int         MAX_N_CH      = 16;
  localparam int         GRANT_W       = $clog2(MAX_N_CH);
  localparam int         PKT_CNT_W     = 16;

  // Width of a channel index for n channels (at least one bit)
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ftdi_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_tx_arbiter_if
//  Purpose  : Bundles the N_CH requester AXI-stream inputs and the merged
//             AXI-stream output of the TX arbiter.
//  Ports    : in_tvalid/in_tready/in_tdata/in_tkeep/in_tlast (per channel,
//             packed channel i at [i*W +: W]); out_tvalid/out_tready/
//             out_tdata/out_tkeep/out_tlast (merged stream).
//             master = arbiter view, slave = surrounding system view.
//  Revision : 1.0  initial release
// ============================================================================
interface ftdi_tx_arbiter_if #(
  parameter int N_CH = 4,
  parameter int EW   = 2
);
  localparam int DW = 8 << EW;
  localparam int KW = 1 << EW;

  logic [N_CH-1:0]    in_tvalid;
  logic [N_CH-1:0]    in_tready;
  logic [N_CH*DW-1:0] in_tdata;
  logic [N_CH*KW-1:0] in_tkeep;
  logic [N_CH-1:0]    in_tlast;

  logic               out_tvalid;
  logic               out_tready;
  logic [DW-1:0]      out_tdata;
  logic [KW-1:0]      out_tkeep;
  logic               out_tlast;

  modport master (
    input  in_tvalid, in_tdata, in_tkeep, in_tlast,
    output in_tready,
    output out_tvalid, out_tdata, out_tkeep, out_tlast,
    input  out_tready
  );

  modport slave (
    output in_tvalid, in_tdata, in_tkeep, in_tlast,
    input  in_tready,
    input  out_tvalid, out_tdata, out_tkeep, out_tlast,
    output out_tready
  );

endinterface
`default_nettype wire

// File: rtl/ftdi_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational N-way round-robin priority select. The winner is
//             the first set request at or after the pointer, wrapping.
//  Ports    : i_req [N]  request vector
//             i_ptr [IW] highest-priority index
//             o_idx [IW] winning index (0 when no request)
//             o_any      at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // One spare bit so ptr+k can exceed N-1 before the wrap correction
  logic [IW:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      if (!o_any && i_req[w_cand[IW-1:0]]) begin
        o_idx = w_cand[IW-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ftdi_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_tx_arbiter
//  Purpose  : Packet-level round-robin arbiter merging N_CH AXI streams onto
//             the single TX stream of the FTDI 245-FIFO controller. A grant
//             is held from first beat to tlast; an optional one-beat header
//             (A5 magic + channel id) precedes each packet.
//  Ports    : clk         user clock (controller tx_clk)
//             rstn_async  asynchronous active-low reset
//             bus         ftdi_tx_arbiter_if.master (inputs + merged output)
//             grant_id    channel currently granted, valid while busy
//             busy        high while a packet (header or data) is in flight
//             pkt_cnt     completed output packets, wraps at 2^16
//  Revision : 1.0  initial release
// ============================================================================
module ftdi_tx_arbiter
  import ftdi_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int EW     = 2,
  parameter int HEADER = 1
) (
  input  logic                 clk,
  input  logic                 rstn_async,
  ftdi_tx_arbiter_if.master    bus,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam int DW = 8 << EW;
  localparam int KW = 1 << EW;
  localparam int CW = ch_idx_w(N_CH);

  logic [STATE_W-1:0]   r_state;
  logic [CW-1:0]        r_grant;
  logic [CW-1:0]        r_rr_ptr;
  logic [PKT_CNT_W-1:0] r_pkt_cnt;

  logic [CW-1:0]        w_win;
  logic                 w_any;
  logic                 w_last_hs;
  logic [CW-1:0]        w_next_ptr;
  logic [DW-1:0]        w_hdr_data;
  logic [DW-1:0]        w_ch_data [N_CH];
  logic [KW-1:0]        w_ch_keep [N_CH];

  // Unpack the flat per-channel buses so the grant can index them directly
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch_data[gi] = bus.in_tdata[gi*DW +: DW];
      assign w_ch_keep[gi] = bus.in_tkeep[gi*KW +: KW];
    end
  endgenerate

  rr_picker #(
    .N  (N_CH),
    .IW (CW)
  ) u_pick (
    .i_req (bus.in_tvalid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  // Header beat only exists when DW >= 16; the HEADER=0 build never reads it
  generate
    if (HEADER != 0) begin : g_hdr
      always_comb begin
        w_hdr_data = '0;
        w_hdr_data[HDR_MAGIC_LSB +: HDR_FIELD_W] = HDR_MAGIC;
        w_hdr_data[HDR_CH_LSB    +: HDR_FIELD_W] = HDR_FIELD_W'(r_grant);
      end
    end else begin : g_no_hdr
      assign w_hdr_data = '0;
    end
  endgenerate

  assign w_last_hs  = (r_state == ST_DATA) && bus.in_tvalid[r_grant] &&
                      bus.out_tready && bus.in_tlast[r_grant];
  // Channel just served drops to lowest priority
  assign w_next_ptr = (r_grant == CW'(N_CH - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_state <= (HEADER != 0) ? ST_HDR : ST_DATA;
          end
        end
        ST_HDR: begin
          if (bus.out_tready) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_last_hs) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output mux. out_tvalid depends only on state and the granted input,
  // never on out_tready.
  always_comb begin
    bus.in_tready  = '0;
    bus.out_tvalid = 1'b0;
    bus.out_tdata  = '0;
    bus.out_tkeep  = '0;
    bus.out_tlast  = 1'b0;
    case (r_state)
      ST_HDR: begin
        bus.out_tvalid = 1'b1;
        bus.out_tdata  = w_hdr_data;
        bus.out_tkeep  = '1;
      end
      ST_DATA: begin
        bus.in_tready[r_grant] = bus.out_tready;
        bus.out_tvalid         = bus.in_tvalid[r_grant];
        bus.out_tdata          = w_ch_data[r_grant];
        bus.out_tkeep          = w_ch_keep[r_grant];
        bus.out_tlast          = bus.in_tlast[r_grant];
      end
      default: ;
    endcase
  end

  assign grant_id = GRANT_W'(r_grant);
  assign busy     = (r_state != ST_IDLE);
  assign pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire
